dsp_sequencer: RTL

Frame-level controller for the DSP core pipeline. It sits between the audio sample-rate strobe and `dsp_core`. Once per sample period it:
- sweeps the instruction-memory read address over the configured program;
- marks which issue slots are valid;
- drains the core pipeline;
- advances the circular sample-buffer offset and I/O bank.

It also flags frames whose program did not finish before the next sample strobe.

---
 rtl/dsp_pkg.sv | 18 +
 rtl/dsp_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared definitions for the DSP core and its frame sequencer.
//   seq_state_t       - sequencer FSM state encoding (IDLE/RUN/DRAIN)
//   INSTR_ADDR_WIDTH  - instruction memory address width
//   SAMPLE_ADDR_WIDTH - sample memory address width
//   PIPE_DEPTH        - dsp_core issue-to-writeback latency in cycles
package dsp_pkg;

  localparam int INSTR_ADDR_WIDTH  = 10;
  localparam int SAMPLE_ADDR_WIDTH = 10;
  localparam int PIPE_DEPTH        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/dsp_sequencer.sv
// dsp_sequencer: once per sample_tick, sweeps the instruction address over
// the active program, drains the core pipeline, then rotates the sample
// buffer offset, flips the I/O bank and counts the frame.
//   clk, reset_n             - clock, async active-low reset
//   sample_tick              - start-of-sample-period strobe
//   cfg_len_wr, cfg_prog_len - pending program length write (clamped)
//   overrun_clr              - clears sticky overrun (a new overrun wins)
//   instr_rd_addr/instr_valid - PC and issue-slot valid
//   sample_offset, io_bank   - per-frame buffer rotation / bank select
//   busy, frame_done, overrun, frame_count - frame status
module dsp_sequencer #(
  parameter int INSTR_ADDR_WIDTH  = dsp_pkg::INSTR_ADDR_WIDTH,
  parameter int SAMPLE_ADDR_WIDTH = dsp_pkg::SAMPLE_ADDR_WIDTH,
  parameter int PIPE_DEPTH        = dsp_pkg::PIPE_DEPTH,
  parameter int DEFAULT_PROG_LEN  = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_tick,
  input  logic                         cfg_len_wr,
  input  logic [INSTR_ADDR_WIDTH:0]    cfg_prog_len,
  input  logic                         overrun_clr,
  output logic [INSTR_ADDR_WIDTH-1:0]  instr_rd_addr,
  output logic                         instr_valid,
  output logic [SAMPLE_ADDR_WIDTH-1:0] sample_offset,
  output logic                         io_bank,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  output logic [15:0]                  frame_count
);
  import dsp_pkg::*;

  localparam int LW = INSTR_ADDR_WIDTH + 1;
  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(2 ** INSTR_ADDR_WIDTH);
  localparam logic [LW-1:0] DEF_LEN =
    (DEFAULT_PROG_LEN > 2 ** INSTR_ADDR_WIDTH) ? MAX_LEN : LW'(DEFAULT_PROG_LEN);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_DEPTH - 1);

  seq_state_t    state;
  logic [LW-1:0] len_pend;
  logic [LW-1:0] len_act;
  logic [DW-1:0] drain_cnt;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] v);
    return (v > MAX_LEN) ? MAX_LEN : v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      len_pend      <= DEF_LEN;
      len_act       <= '0;
      drain_cnt     <= '0;
      instr_rd_addr <= '0;
      instr_valid   <= 1'b0;
      sample_offset <= '0;
      io_bank       <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      frame_count   <= '0;
    end else begin
      frame_done <= 1'b0;

      // The tick that starts a frame reads the old pending length.
      if (cfg_len_wr) len_pend <= clamp_len(cfg_prog_len);

      // Ticks outside IDLE are dropped; set has priority over clear.
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      else if (overrun_clr)             overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (sample_tick) begin
            len_act   <= len_pend;
            busy      <= 1'b1;
            drain_cnt <= '0;
            if (len_pend != '0) begin
              state         <= RUN;
              instr_rd_addr <= '0;
              instr_valid   <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        RUN: begin
          // PC stays on the last issued address through DRAIN.
          if ({1'b0, instr_rd_addr} == len_act - LW'(1)) begin
            state       <= DRAIN;
            instr_valid <= 1'b0;
            drain_cnt   <= '0;
          end else begin
            instr_rd_addr <= instr_rd_addr + INSTR_ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state         <= IDLE;
            busy          <= 1'b0;
            frame_done    <= 1'b1;
            sample_offset <= sample_offset - SAMPLE_ADDR_WIDTH'(1);
            io_bank       <= ~io_bank;
            frame_count   <= frame_count + 16'd1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
